// File: rtl/sub_bytes_pipe.sv
// Two-stage AES SubBytes / InvSubBytes pipeline over LANES byte lanes with
// valid/ready handshakes on both sides and a saturating output-transfer counter.
module sub_bytes_pipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_inv,
  input  logic                 clr,
  output logic [CNT_W-1:0]     xfer_cnt
);

  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  logic               r_live;
  logic               r_s1_v;
  logic               r_s1_inv;
  logic [8*LANES-1:0] r_s1_data;
  logic               r_s2_v;
  logic               r_s2_inv;
  logic [8*LANES-1:0] r_s2_data;
  logic [CNT_W-1:0]   r_cnt;
  logic [8*LANES-1:0] w_sub;
  logic               w_s2_load;
  logic               w_in_hs;
  logic               w_out_hs;

  assign w_out_hs  = r_s2_v & out_ready;
  assign w_s2_load = ~r_s2_v | out_ready;
  // r_live keeps in_ready low through reset and until the first edge after release
  assign in_ready  = r_live & (~r_s1_v | w_s2_load);
  assign w_in_hs   = in_valid & in_ready;

  assign out_valid = r_s2_v;
  assign out_data  = r_s2_data;
  assign out_inv   = r_s2_inv;
  assign xfer_cnt  = r_cnt;

  always_comb begin
    w_sub = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_sub[8*k +: 8] = r_s1_inv ? INV_SBOX[r_s1_data[8*k +: 8]]
                                 : FWD_SBOX[r_s1_data[8*k +: 8]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_s1_v    <= 1'b0;
      r_s1_inv  <= 1'b0;
      r_s1_data <= '0;
      r_s2_v    <= 1'b0;
      r_s2_inv  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_in_hs) begin
        r_s1_v    <= 1'b1;
        r_s1_data <= in_data;
        r_s1_inv  <= in_inv;
      end else if (w_s2_load) begin
        r_s1_v <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_data <= w_sub;
          r_s2_inv  <= r_s1_inv;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_out_hs && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Scoreboard bench for sub_bytes_pipe: S-box reference computed from GF(2^8)
// inversion plus the AES affine map; a negedge monitor pops and compares outputs.
module tb_sub_bytes_pipe;
  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                clk, rst_n, in_valid, in_ready, in_inv;
  logic                out_valid, out_ready, out_inv, clr;
  logic [8*LANES-1:0]  in_data, out_data;
  logic [CNT_W-1:0]    xfer_cnt;

  sub_bytes_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv),
    .clr(clr), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic inv; } beat_t;
  beat_t       exp_q[$];
  logic [31:0] cap_q[$];
  logic [7:0]  fwd_tab [256];
  logic [7:0]  inv_tab [256];
  int          n_total = 0, n_bad = 0;
  int          m_cnt = 0, cyc = 0;
  int          hs_n = 0, hs_first = 0, hs_last = 0;
  logic [31:0] drv_exp = '0;
  logic        drv_exp_inv = 1'b0;
  logic        rnd_mode = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] v = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
    logic [31:0] r = '0;
    for (int k = 0; k < LANES; k++)
      r[8*k +: 8] = inv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
    return r;
  endfunction

  // Monitor: decisions made at negedge are the handshakes of the following posedge.
  initial begin
    beat_t       b;
    logic        ohs;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_inv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        m_cnt = 0;
        prev_stall = 1'b0;
      end else begin
        chk("xfer_cnt", 32'(xfer_cnt), m_cnt);
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_d);
          chk("hold_inv", out_inv, prev_inv);
        end
        ohs = out_valid && out_ready;
        if (ohs) begin
          if (exp_q.size() == 0) begin
            n_total++; n_bad++;
            $display("FAIL spurious_out: actual=%h required=no_beat", out_data);
          end else begin
            b = exp_q.pop_front();
            chk("out_data", out_data, b.d);
            chk("out_inv", out_inv, b.inv);
          end
          cap_q.push_back(out_data);
          if (hs_n == 0) hs_first = cyc;
          hs_last = cyc;
          hs_n++;
        end
        if (in_valid && in_ready) exp_q.push_back('{drv_exp, drv_exp_inv});
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
        prev_inv = out_inv;
        if (clr) m_cnt = 0;
        else if (ohs && m_cnt != CNT_MAX) m_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] d, input logic inv, input logic [31:0] e);
    int  t = 0;
    logic acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    drv_exp = e; drv_exp_inv = inv;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_total++; n_bad++;
      $display("FAIL send_timeout: actual=not_accepted required=accepted data=%h", d);
    end
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) begin
      n_total++; n_bad++;
      $display("FAIL drain_timeout: actual=%0d required=0", exp_q.size());
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bp [3];
    logic        bpi [3];
    logic [31:0] d, rt_out [$];
    logic        a;
    int          idx, c0;

    for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_ref(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0;
    out_ready = 1'b1; clr = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_inv", out_inv, 0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
    chk("rst_in_ready", in_ready, 0);
    #20;
    chk("rst_in_ready_held", in_ready, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release", in_ready, 1);

    // Forward vector with latency check
    pulse_clr();
    send(32'hFF53_0100, 1'b0, 32'h16ED_7C63);
    chk("lat_not_yet", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 32'h16ED_7C63);
    chk("lat_inv", out_inv, 0);
    @(posedge clk); #1;
    chk("fwd_xfer_cnt", 32'(xfer_cnt), 1);

    send(32'h16ED_7C63, 1'b1, 32'hFF53_0100);
    drain();

    // Exhaustive round trip: forward all 256 values, feed results back inverse
    cap_q.delete();
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(4*i + k);
      send(d, 1'b0, model(d, 1'b0));
    end
    drain();
    chk("rt_fwd_count", cap_q.size(), 64);
    rt_out = cap_q;
    for (int i = 0; i < rt_out.size(); i++) begin
      for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(4*i + k);
      send(rt_out[i], 1'b1, d);
    end
    drain();

    // Backpressure: three beats offered while output stalled
    pulse_clr();
    out_ready = 1'b0;
    bp[0] = 32'h0011_2233; bpi[0] = 1'b0;
    bp[1] = 32'hA5A5_5A5A; bpi[1] = 1'b1;
    bp[2] = 32'hDEAD_BEEF; bpi[2] = 1'b0;
    idx = 0;
    in_valid = 1'b1; in_data = bp[0]; in_inv = bpi[0];
    drv_exp = model(bp[0], bpi[0]); drv_exp_inv = bpi[0];
    repeat (6) begin
      @(negedge clk); a = in_ready;
      @(posedge clk); #1;
      if (a && idx < 3) begin
        idx++;
        if (idx < 3) begin
          in_data = bp[idx]; in_inv = bpi[idx];
          drv_exp = model(bp[idx], bpi[idx]); drv_exp_inv = bpi[idx];
        end else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    send(bp[2], bpi[2], model(bp[2], bpi[2]));
    drain();
    chk("bp_xfer_cnt", 32'(xfer_cnt), 3);

    // Alternating mode at full rate
    hs_n = 0;
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      send(32'h5252_5252, i[0], i[0] ? 32'h4848_4848 : 32'h0000_0000);
    chk("alt_in_cycles", cyc - c0, 16);
    drain();
    chk("alt_out_count", hs_n, 16);
    chk("alt_out_span", hs_last - hs_first, 15);

    // Random traffic with random backpressure and occasional clr
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end else begin
        d = $urandom;
        a = 1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 31) == 0);
        send(d, a, model(d, a));
        clr = 1'b0;
      end
    end
    rnd_mode = 1'b0;
    #2;
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(32'h0102_0304, 1'b0, model(32'h0102_0304, 1'b0));
    send(32'hCAFE_F00D, 1'b1, model(32'hCAFE_F00D, 1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_xfer_cnt", 32'(xfer_cnt), 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready_back", in_ready, 1);
    repeat (4) begin
      chk("no_stale_beat", out_valid, 0);
      @(posedge clk); #1;
    end

    // Counter saturation, then clr colliding with a handshake
    pulse_clr();
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      send(d, 1'b0, model(d, 1'b0));
    end
    drain();
    chk("sat_xfer_cnt", 32'(xfer_cnt), CNT_MAX);
    out_ready = 1'b0;
    send(32'h1234_5678, 1'b0, model(32'h1234_5678, 1'b0));
    @(posedge clk); #1;
    chk("clr_hs_valid", out_valid, 1);
    clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_hs_xfer_cnt", 32'(xfer_cnt), 0);
    chk("clr_hs_consumed", out_valid, 0);

    drain();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
